// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL sequencer: FSM state encoding and MD port opcodes.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RST_ASSERT = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_LOCKED     = 3'd2,
      ST_MD_ADDR    = 3'd3,
      ST_MD_OP      = 3'd4,
      ST_MD_RD      = 3'd5,
      ST_FAIL       = 3'd6
   } state_e;

   localparam logic [1:0] MD_NOP  = 2'b00;
   localparam logic [1:0] MD_ADDR = 2'b01;
   localparam logic [1:0] MD_WR   = 2'b10;
   localparam logic [1:0] MD_RD   = 2'b11;

endpackage

// File: rtl/pll_ctrl_lock_filter.sv
// Two-flop synchroniser for the asynchronous PLL LOCK plus a consecutive-high sample counter.
module pll_ctrl_lock_filter #(
   parameter int unsigned LOCK_FILTER = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic lock_i,
   input  logic clear_i,
   output logic lock_s_o,
   output logic ok_c_o
);

   localparam int unsigned FILT_W = $clog2(LOCK_FILTER + 1);

   logic [1:0]        sync_q;
   logic [FILT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], lock_i};
         cnt_q  <= cnt_d;
      end
   end

   // Any low sample restarts the run; the count saturates so it can never wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || !sync_q[1]) begin
         cnt_d = '0;
      end else if (cnt_q != FILT_W'(LOCK_FILTER)) begin
         cnt_d = cnt_q + FILT_W'(1);
      end
   end

   // High on the sample that completes the run, so the FSM can act on that same edge.
   assign ok_c_o   = !clear_i && sync_q[1] && (cnt_q == FILT_W'(LOCK_FILTER - 1));
   assign lock_s_o = sync_q[1];

endmodule

// File: rtl/pll_ctrl.sv
// PLL reset/lock sequencer with retry and a single-requester byte bridge onto the MD config port.
module pll_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = 16,
   parameter int unsigned LOCK_FILTER  = 8,
   parameter int unsigned LOCK_TIMEOUT = 65535,
   parameter int unsigned MAX_RETRIES  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock_i,
   output logic       pll_reset_o,
   output logic [1:0] md_opc_o,
   output logic [7:0] md_wdi_o,
   input  logic [7:0] md_rdo_i,
   input  logic       cfg_req_i,
   input  logic       cfg_we_i,
   input  logic [7:0] cfg_addr_i,
   input  logic [7:0] cfg_wdata_i,
   output logic       cfg_ack_o,
   output logic [7:0] cfg_rdata_o,
   output logic       clk_ok_o,
   output logic       fail_o,
   output logic [2:0] state_o
);

   localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);
   localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);

   state_e             state_q, state_d;
   logic               pll_reset_q, pll_reset_d;
   logic [1:0]         opc_q, opc_d;
   logic [7:0]         wdi_q, wdi_d;
   logic               ack_q, ack_d;
   logic [7:0]         rdata_q, rdata_d;
   logic               clk_ok_q, clk_ok_d;
   logic               fail_q, fail_d;
   logic               lost_q, lost_d;
   logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [RTY_W-1:0]   retry_q, retry_d;
   logic [RTY_W-1:0]   retry_inc;
   logic               lock_s;
   logic               filt_ok_c;
   logic               filt_clear;

   assign filt_clear = (state_q != ST_WAIT_LOCK);
   assign retry_inc  = retry_q + RTY_W'(1);

   pll_ctrl_lock_filter #(
      .LOCK_FILTER (LOCK_FILTER)
   ) u_lock_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .lock_i   (pll_lock_i),
      .clear_i  (filt_clear),
      .lock_s_o (lock_s),
      .ok_c_o   (filt_ok_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RST_ASSERT;
         pll_reset_q <= 1'b1;
         opc_q       <= MD_NOP;
         wdi_q       <= '0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
         clk_ok_q    <= 1'b0;
         fail_q      <= 1'b0;
         lost_q      <= 1'b0;
         rst_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         retry_q     <= '0;
      end else begin
         state_q     <= state_d;
         pll_reset_q <= pll_reset_d;
         opc_q       <= opc_d;
         wdi_q       <= wdi_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         clk_ok_q    <= clk_ok_d;
         fail_q      <= fail_d;
         lost_q      <= lost_d;
         rst_cnt_q   <= rst_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         retry_q     <= retry_d;
      end
   end

   // Outputs are registered from the next state so each one lines up with state_o.
   always_comb begin
      state_d     = state_q;
      pll_reset_d = pll_reset_q;
      opc_d       = MD_NOP;
      wdi_d       = '0;
      ack_d       = 1'b0;
      rdata_d     = rdata_q;
      clk_ok_d    = clk_ok_q;
      fail_d      = fail_q;
      lost_d      = lost_q;
      rst_cnt_d   = '0;
      tmo_cnt_d   = '0;
      retry_d     = retry_q;

      unique case (state_q)
         ST_RST_ASSERT: begin
            pll_reset_d = 1'b1;
            if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
               state_d     = ST_WAIT_LOCK;
               pll_reset_d = 1'b0;
            end else begin
               rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
         end

         ST_WAIT_LOCK: begin
            if (filt_ok_c) begin
               state_d  = ST_LOCKED;
               clk_ok_d = 1'b1;
               retry_d  = '0;
            end else if (tmo_cnt_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
               retry_d     = retry_inc;
               pll_reset_d = 1'b1;
               if (retry_inc == RTY_W'(MAX_RETRIES)) begin
                  state_d = ST_FAIL;
                  fail_d  = 1'b1;
               end else begin
                  state_d = ST_RST_ASSERT;
               end
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end

         // ack_q blocks re-acceptance while the requester is still dropping its request.
         ST_LOCKED: begin
            if (!lock_s) begin
               state_d     = ST_RST_ASSERT;
               clk_ok_d    = 1'b0;
               pll_reset_d = 1'b1;
            end else if (cfg_req_i && !ack_q) begin
               state_d = ST_MD_ADDR;
               opc_d   = MD_ADDR;
               wdi_d   = cfg_addr_i;
               lost_d  = 1'b0;
            end
         end

         ST_MD_ADDR: begin
            lost_d  = lost_q | ~lock_s;
            state_d = ST_MD_OP;
            opc_d   = cfg_we_i ? MD_WR : MD_RD;
            wdi_d   = cfg_we_i ? cfg_wdata_i : 8'h00;
         end

         // A write always forces a relock; it is also the only exit from FAIL.
         ST_MD_OP: begin
            lost_d = lost_q | ~lock_s;
            if (cfg_we_i) begin
               state_d     = ST_RST_ASSERT;
               ack_d       = 1'b1;
               clk_ok_d    = 1'b0;
               pll_reset_d = 1'b1;
               fail_d      = 1'b0;
               retry_d     = '0;
            end else begin
               state_d = ST_MD_RD;
            end
         end

         ST_MD_RD: begin
            rdata_d = md_rdo_i;
            ack_d   = 1'b1;
            if (lost_q || !lock_s) begin
               state_d     = ST_RST_ASSERT;
               clk_ok_d    = 1'b0;
               pll_reset_d = 1'b1;
            end else begin
               state_d = ST_LOCKED;
            end
         end

         ST_FAIL: begin
            pll_reset_d = 1'b1;
            fail_d      = 1'b1;
            clk_ok_d    = 1'b0;
            if (cfg_req_i && !ack_q) begin
               if (cfg_we_i) begin
                  state_d = ST_MD_ADDR;
                  opc_d   = MD_ADDR;
                  wdi_d   = cfg_addr_i;
                  lost_d  = 1'b0;
               end else begin
                  ack_d = 1'b1;
               end
            end
         end

         default: begin
            state_d     = ST_RST_ASSERT;
            pll_reset_d = 1'b1;
            clk_ok_d    = 1'b0;
         end
      endcase
   end

   assign pll_reset_o = pll_reset_q;
   assign md_opc_o    = opc_q;
   assign md_wdi_o    = wdi_q;
   assign cfg_ack_o   = ack_q;
   assign cfg_rdata_o = rdata_q;
   assign clk_ok_o    = clk_ok_q;
   assign fail_o      = fail_q;
   assign state_o     = state_q;

endmodule
